// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops core writes to $4014, halts the core and copies one page to OAM.
// Optional stall counter on O_stall_cycles is enabled by defining OAM_DMA_STALL_COUNT_EN.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_cycle_en,
    input  logic [15:0] I_cpu_addr,
    input  logic [7:0]  I_cpu_wr_data,
    input  logic        I_cpu_rdwr,
    input  logic [7:0]  I_rd_data,
    output logic        O_cpu_ready,
    output logic [15:0] O_addr,
    output logic [7:0]  O_wr_data,
    output logic        O_rdwr,
    output logic        O_busy,
    output logic [15:0] O_stall_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        GET,
        PUT
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'(XFER_LEN - 1);

    state_t     state;
    logic       parity;
    logic [7:0] index;
    logic [7:0] page;
    logic [7:0] latch;
    logic       ready_q;
    logic       trigger_hit;
    logic       halting_read;

    assign trigger_hit  = (state == IDLE) && !I_cpu_rdwr && (I_cpu_addr == DMA_REG_ADDR);
    // The core must see ready low during the very read it is being halted on.
    assign halting_read = (state == HALT) && I_cpu_rdwr;
    assign O_cpu_ready  = ready_q && !halting_read;
    assign O_busy       = (state != IDLE);

    // NOTE: reset is honoured on every clock edge, not only on cycle_en, so an abort takes effect at once.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state   <= IDLE;
            parity  <= 1'b0;
            index   <= 8'h00;
            page    <= 8'h00;
            latch   <= 8'h00;
            ready_q <= 1'b1;
        end else if (I_cycle_en) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (trigger_hit) begin
                        page  <= I_cpu_wr_data;
                        index <= 8'h00;
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (I_cpu_rdwr) begin
                        ready_q <= 1'b0;
                        state   <= parity ? GET : ALIGN;
                    end
                end
                ALIGN: state <= GET;
                GET: begin
                    latch <= I_rd_data;
                    state <= PUT;
                end
                PUT: begin
                    index <= index + 8'd1;
                    if (index == LAST_INDEX) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= GET;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // HALT forwards the core cycle as-is: writes complete, the halting read is repeated next cycle.
    always_comb begin
        O_addr    = I_cpu_addr;
        O_wr_data = I_cpu_wr_data;
        O_rdwr    = I_cpu_rdwr;
        case (state)
            ALIGN: O_rdwr = 1'b1;
            GET: begin
                O_addr = {page, index};
                O_rdwr = 1'b1;
            end
            PUT: begin
                O_addr    = OAM_DATA_ADDR;
                O_wr_data = latch;
                O_rdwr    = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef OAM_DMA_STALL_COUNT_EN
    logic [15:0] stall_count;

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            stall_count <= 16'h0000;
        end else if (I_cycle_en) begin
            if (trigger_hit) begin
                stall_count <= 16'h0000;
            end else if (!O_cpu_ready) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign O_stall_cycles = stall_count;
`else
    assign O_stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: scoreboard of expected OAM bytes plus cycle-accurate halt timing.
module tb_oam_dma;

    localparam logic [15:0] OAM_ADDR = 16'h2004;
    localparam logic [15:0] CPU_RD   = 16'h8000;

    logic        I_clock = 1'b0;
    logic        I_reset;
    logic        I_cycle_en;
    logic [15:0] I_cpu_addr;
    logic [7:0]  I_cpu_wr_data;
    logic        I_cpu_rdwr;
    logic [7:0]  I_rd_data;
    logic        O_cpu_ready;
    logic [15:0] O_addr;
    logic [7:0]  O_wr_data;
    logic        O_rdwr;
    logic        O_busy;
    logic [15:0] O_stall_cycles;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [7:0]  sb[$];

    logic        s_ready;
    logic        s_busy;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;
    logic        s_rdwr;
    logic [15:0] s_stall;

    oam_dma dut (
        .I_clock        (I_clock),
        .I_reset        (I_reset),
        .I_cycle_en     (I_cycle_en),
        .I_cpu_addr     (I_cpu_addr),
        .I_cpu_wr_data  (I_cpu_wr_data),
        .I_cpu_rdwr     (I_cpu_rdwr),
        .I_rd_data      (I_rd_data),
        .O_cpu_ready    (O_cpu_ready),
        .O_addr         (O_addr),
        .O_wr_data      (O_wr_data),
        .O_rdwr         (O_rdwr),
        .O_busy         (O_busy),
        .O_stall_cycles (O_stall_cycles)
    );

    always #5 I_clock = ~I_clock;

    // Page $07 holds byte i at $07ii; other pages hold a scrambled pattern.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a[15:8] == 8'h07) ? a[7:0] : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    assign I_rd_data = mem_byte(O_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One CPU cycle of two clocks; outputs are sampled mid-cycle, cycle_en pulses on the second edge.
    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge I_clock);
        I_cycle_en    = 1'b0;
        I_cpu_addr    = a;
        I_cpu_wr_data = d;
        I_cpu_rdwr    = rw;
        @(negedge I_clock);
        I_cycle_en = 1'b1;
        s_ready    = O_cpu_ready;
        s_busy     = O_busy;
        s_addr     = O_addr;
        s_wdata    = O_wr_data;
        s_rdwr     = O_rdwr;
        s_stall    = O_stall_cycles;
        @(posedge I_clock);
        #1 I_cycle_en = 1'b0;
        cycle++;
    endtask

    task automatic do_reset();
        @(negedge I_clock);
        I_reset       = 1'b1;
        I_cycle_en    = 1'b0;
        I_cpu_addr    = CPU_RD;
        I_cpu_wr_data = 8'h00;
        I_cpu_rdwr    = 1'b1;
        repeat (3) @(posedge I_clock);
        @(negedge I_clock);
        I_reset = 1'b0;
        cycle   = 0;
        sb.delete();
        check("rst_ready", O_cpu_ready, 1'b1);
        check("rst_busy", O_busy, 1'b0);
        check("rst_stall", O_stall_cycles, 16'h0000);
        check("rst_pass_addr", O_addr, CPU_RD);
    endtask

    task automatic run_xfer(input int trig, input int n_wr, input logic [7:0] page, input int abort_at,
                            input int exp_halt, input int exp_get, input int exp_back, input int exp_stall);
        int          halt_c   = -1;
        int          get_c    = -1;
        int          back_c   = -1;
        int          zero_n   = 0;
        int          puts     = 0;
        int          cur;
        bit          overflow = 1'b0;
        logic [15:0] wa;
        logic [7:0]  wd;
        do_reset();
        while (cycle < trig) begin
            cpu_cycle(CPU_RD, 8'h00, 1'b1);
            check("idle_busy", s_busy, 1'b0);
        end
        cpu_cycle(16'h4014, page, 1'b0);
        check("trig_pass_addr", s_addr, 16'h4014);
        check("trig_pass_data", s_wdata, page);
        for (int i = 0; i < 256; i++) sb.push_back(mem_byte({page, 8'(i)}));
        for (int k = 0; k < n_wr; k++) begin
            // First extra write retriggers $4014 with another page; it must be ignored.
            wa = (k == 0) ? 16'h4014 : 16'(16'h01FD - k);
            wd = (k == 0) ? 8'h05 : 8'hC0;
            cpu_cycle(wa, wd, 1'b0);
            check("wr_ready", s_ready, 1'b1);
            check("wr_busy", s_busy, 1'b1);
            check("wr_pass_addr", s_addr, wa);
            check("wr_pass_rdwr", s_rdwr, 1'b0);
        end
        for (int n = 0; n < 700; n++) begin
            cpu_cycle(CPU_RD, 8'h00, 1'b1);
            cur = cycle - 1;
            if (!s_ready) begin
                zero_n++;
                if (halt_c < 0) halt_c = cur;
            end
            if (s_busy && s_rdwr && s_addr == {page, 8'h00} && get_c < 0) get_c = cur;
            if (s_busy && s_addr == {8'(page + 8'd1), 8'h00}) overflow = 1'b1;
            if (!s_rdwr && s_addr == OAM_ADDR) begin
                puts++;
                if (sb.size() == 0) check("put_extra", puts, 256);
                else check("put_data", s_wdata, sb.pop_front());
            end
            if (abort_at >= 0 && cur == abort_at) begin
                check("abort_puts_before", puts, 100);
                @(negedge I_clock);
                I_reset = 1'b1;
                @(posedge I_clock);
                #1 I_reset = 1'b0;
                cpu_cycle(CPU_RD, 8'h00, 1'b1);
                check("abort_ready", s_ready, 1'b1);
                check("abort_busy", s_busy, 1'b0);
                check("abort_pass_addr", s_addr, CPU_RD);
                check("abort_pass_rdwr", s_rdwr, 1'b1);
                puts = 0;
                repeat (20) begin
                    cpu_cycle(CPU_RD, 8'h00, 1'b1);
                    if (!s_rdwr && s_addr == OAM_ADDR) puts++;
                end
                check("abort_no_puts", puts, 0);
                return;
            end
            if (halt_c >= 0 && s_ready) begin
                back_c = cur;
                break;
            end
        end
        check("halt_cycle", halt_c, exp_halt);
        check("first_get_cycle", get_c, exp_get);
        check("ready_back_cycle", back_c, exp_back);
        check("stall_len", zero_n, exp_stall);
        check("put_count", puts, 256);
        check("sb_empty", sb.size(), 0);
        check("no_page_carry", overflow, 1'b0);
        check("done_busy", s_busy, 1'b0);
`ifdef OAM_DMA_STALL_COUNT_EN
        check("stall_out", s_stall, exp_stall);
        cpu_cycle(CPU_RD, 8'h00, 1'b1);
        check("stall_hold", s_stall, exp_stall);
`else
        check("stall_out", s_stall, 16'h0000);
`endif
    endtask

    initial begin
        I_reset       = 1'b1;
        I_cycle_en    = 1'b0;
        I_cpu_addr    = CPU_RD;
        I_cpu_wr_data = 8'h00;
        I_cpu_rdwr    = 1'b1;

        // Halt on an odd cycle: no align slot.
        run_xfer(10, 0, 8'h02, -1, 11, 12, 524, 513);
        // Halt on an even cycle: one align slot.
        run_xfer(11, 0, 8'h02, -1, 12, 14, 526, 514);
        // Two core writes after the trigger (the first a retrigger) delay the halt.
        run_xfer(10, 2, 8'h03, -1, 13, 14, 526, 513);
        // Identity page: puts carry $00..$FF in order, never reaching $0800.
        run_xfer(10, 0, 8'h07, -1, 11, 12, 524, 513);
        // Reset mid-transfer during the get of index 100.
        run_xfer(10, 0, 8'h02, 212, 11, 12, 524, 513);

        // Near-miss accesses must not start a transfer.
        do_reset();
        cpu_cycle(16'h4015, 8'h02, 1'b0);
        check("miss_wr4015_busy", s_busy, 1'b0);
        cpu_cycle(16'h4014, 8'h02, 1'b1);
        check("miss_rd4014_busy", s_busy, 1'b0);
        repeat (3) begin
            cpu_cycle(CPU_RD, 8'h00, 1'b1);
            check("miss_busy", s_busy, 1'b0);
            check("miss_ready", s_ready, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
